// File: rtl/seg_pkg.sv
// Shared types for the seven-segment scan controller.
// Digit codes are {enable, hex nibble}; a cleared enable bit blanks the digit.
package seg_pkg;

  typedef logic [4:0] seg_code_t;

  localparam seg_code_t SEG_BLANK = '0;

  typedef enum logic {
    BLANK,
    ON
  } scan_state_t;

endpackage

// File: rtl/hex2physical.sv
// Hex digit to active-low segment pattern {CA..CG, DP}.
// A code whose enable bit is clear lights nothing.
module hex2physical
  import seg_pkg::*;
(
  input  seg_code_t  code,
  output logic [7:0] seg
);

  logic [6:0] abcdefg;

  // Segment pattern for the nibble, active low, before enable gating.
  always_comb begin
    abcdefg = 7'b111_1111;
    unique case (code[3:0])
      4'h0: abcdefg = 7'b000_0001;
      4'h1: abcdefg = 7'b100_1111;
      4'h2: abcdefg = 7'b001_0010;
      4'h3: abcdefg = 7'b000_0110;
      4'h4: abcdefg = 7'b100_1100;
      4'h5: abcdefg = 7'b010_0100;
      4'h6: abcdefg = 7'b010_0000;
      4'h7: abcdefg = 7'b000_1111;
      4'h8: abcdefg = 7'b000_0000;
      4'h9: abcdefg = 7'b000_0100;
      4'hA: abcdefg = 7'b000_1000;
      4'hB: abcdefg = 7'b110_0000;
      4'hC: abcdefg = 7'b011_0001;
      4'hD: abcdefg = 7'b100_0010;
      4'hE: abcdefg = 7'b011_0000;
      4'hF: abcdefg = 7'b011_1000;
      default: abcdefg = 7'b111_1111;
    endcase
  end

  // Decimal point is never lit; disabled digits go fully dark.
  always_comb begin
    seg = 8'hFF;
    if (code[4]) begin
      seg = {abcdefg, 1'b1};
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan of a common-anode display bank with
// blanking gaps and frame-atomic, double-buffered updates.
module seven_seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [4*N_DIGITS-1:0] wr_data,
  input  logic [N_DIGITS-1:0]   wr_mask,
  output logic [N_DIGITS-1:0]   anodes,
  output logic [7:0]            cathodes,
  output logic                  update_pending,
  output logic                  frame_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] DIG_LAST   = IW'(N_DIGITS - 1);

  scan_state_t         state;
  logic [CW-1:0]       slot_cnt;
  logic [IW-1:0]       digit_idx;

  seg_code_t           act_code [N_DIGITS];
  seg_code_t           shd_code [N_DIGITS];
  seg_code_t           wr_code  [N_DIGITS];

  seg_code_t           cur_code;
  logic [7:0]          seg;
  logic [N_DIGITS-1:0] sel;

  logic                commit_wr;
  logic                commit_shd;
  logic                load_shd;

  // Last cycle of the final digit slot marks the frame boundary.
  always_comb begin
    frame_done = !rst
              && (state == ON)
              && (digit_idx == DIG_LAST)
              && (slot_cnt == SLOT_LAST);
  end

  // Pack the bus write into per-digit codes.
  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      wr_code[i] = {wr_mask[i], wr_data[4*i +: 4]};
    end
  end

  // Select the code and anode for the current slot phase.
  always_comb begin
    cur_code = SEG_BLANK;
    sel      = '1;
    if (state == ON) begin
      cur_code       = act_code[digit_idx];
      sel[digit_idx] = 1'b0;
    end
  end

  hex2physical u_dec (
    .code (cur_code),
    .seg  (seg)
  );

  // Scan FSM: slot timing, digit rotation and registered pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BLANK;
      slot_cnt  <= '0;
      digit_idx <= '0;
      anodes    <= '1;
      cathodes  <= 8'hFF;
    end else begin
      anodes   <= sel;
      cathodes <= seg;
      unique case (state)
        BLANK: begin
          slot_cnt <= slot_cnt + 1'b1;
          if (slot_cnt == BLANK_LAST) begin
            state <= ON;
          end
        end
        ON: begin
          if (slot_cnt == SLOT_LAST) begin
            slot_cnt  <= '0;
            state     <= BLANK;
            digit_idx <= (digit_idx == DIG_LAST)
                       ? '0
                       : digit_idx + 1'b1;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

  // A write landing on the boundary bypasses the shadow into active.
  always_comb begin
    commit_wr  = frame_done && wr_en;
    commit_shd = frame_done && !wr_en && update_pending;
    load_shd   = !frame_done && wr_en;
  end

  // Double buffer: shadow collects writes, active swaps per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        act_code[i] <= SEG_BLANK;
        shd_code[i] <= SEG_BLANK;
      end
      update_pending <= 1'b0;
    end else begin
      unique case (1'b1)
        commit_wr: begin
          for (int i = 0; i < N_DIGITS; i++) begin
            act_code[i] <= wr_code[i];
            shd_code[i] <= wr_code[i];
          end
          update_pending <= 1'b0;
        end
        commit_shd: begin
          for (int i = 0; i < N_DIGITS; i++) begin
            act_code[i] <= shd_code[i];
          end
          update_pending <= 1'b0;
        end
        load_shd: begin
          for (int i = 0; i < N_DIGITS; i++) begin
            shd_code[i] <= wr_code[i];
          end
          update_pending <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for the scan controller: 4 digits,
// 8-cycle slots, 2 blank cycles, hand-computed pin values.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_mask;
  logic [3:0]  anodes;
  logic [7:0]  cathodes;
  logic        update_pending;
  logic        frame_done;

  int n_vec = 0;
  int n_bad = 0;
  int k     = 0;

  seven_seg_scan_ctrl #(
    .N_DIGITS     (4),
    .SLOT_CYCLES  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wr_mask        (wr_mask),
    .anodes         (anodes),
    .cathodes       (cathodes),
    .update_pending (update_pending),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic go(input int t);
    while (k < t) tick();
  endtask

  task automatic wr(input logic [15:0] d, input logic [3:0] m);
    wr_en   = 1'b1;
    wr_data = d;
    wr_mask = m;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_slot(
    input int         base,
    input int         d,
    input logic [7:0] cat
  );
    logic [3:0] an;
    an = ~(4'b0001 << d);
    go(base + 8*d + 1);
    chk("blank0_an", anodes, 4'hF);
    chk("blank0_cat", cathodes, 8'hFF);
    go(base + 8*d + 2);
    chk("blank1_an", anodes, 4'hF);
    chk("blank1_cat", cathodes, 8'hFF);
    go(base + 8*d + 3);
    chk("on_first_an", anodes, an);
    chk("on_first_cat", cathodes, cat);
    go(base + 8*d + 8);
    chk("on_last_an", anodes, an);
    chk("on_last_cat", cathodes, cat);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    wr_mask = '0;

    repeat (3) begin
      tick();
      chk("rst_an", anodes, 4'hF);
      chk("rst_cat", cathodes, 8'hFF);
      chk("rst_pend", update_pending, 1'b0);
      chk("rst_fd", frame_done, 1'b0);
    end
    rst = 1'b0;
    k   = 0;

    go(2);
    chk("pre_on_an", anodes, 4'hF);
    go(3);
    chk("first_on_an", anodes, 4'hE);
    chk("first_on_cat", cathodes, 8'hFF);

    wr(16'h3210, 4'hF);
    chk("wr_pend", update_pending, 1'b1);
    go(30);
    chk("fd_early", frame_done, 1'b0);
    go(31);
    chk("fd_pulse", frame_done, 1'b1);
    chk("fd_pend", update_pending, 1'b1);
    go(32);
    chk("commit_pend", update_pending, 1'b0);
    chk("wrap_an", anodes, 4'h7);
    chk("wrap_cat", cathodes, 8'hFF);

    check_slot(32, 0, 8'h03);
    wr(16'hFFFF, 4'hF);
    chk("mid_pend", update_pending, 1'b1);
    check_slot(32, 1, 8'h9F);
    check_slot(32, 2, 8'h25);
    check_slot(32, 3, 8'h0D);
    chk("atomic_pend", update_pending, 1'b0);

    check_slot(64, 0, 8'h71);
    wr(16'h3210, 4'b1011);
    chk("mask_pend", update_pending, 1'b1);

    check_slot(96, 0, 8'h03);
    check_slot(96, 1, 8'h9F);
    wr(16'h5555, 4'hF);
    check_slot(96, 2, 8'hFF);
    go(123);
    chk("d3_an", anodes, 4'h7);
    chk("d3_cat", cathodes, 8'h0D);
    go(127);
    chk("coll_fd", frame_done, 1'b1);
    chk("coll_pend_pre", update_pending, 1'b1);
    wr(16'hAAAA, 4'hF);
    chk("coll_pend", update_pending, 1'b0);
    chk("coll_old_cat", cathodes, 8'h0D);

    check_slot(128, 0, 8'h11);
    check_slot(128, 1, 8'h11);
    go(147);
    chk("pre_rst_an", anodes, 4'hB);
    chk("pre_rst_cat", cathodes, 8'h11);

    rst = 1'b1;
    tick();
    chk("mid_rst_an", anodes, 4'hF);
    chk("mid_rst_cat", cathodes, 8'hFF);
    chk("mid_rst_pend", update_pending, 1'b0);
    chk("mid_rst_fd", frame_done, 1'b0);
    rst = 1'b0;
    k   = 0;

    go(3);
    chk("dark_d0_an", anodes, 4'hE);
    chk("dark_d0_cat", cathodes, 8'hFF);
    go(11);
    chk("dark_d1_an", anodes, 4'hD);
    chk("dark_d1_cat", cathodes, 8'hFF);
    go(31);
    chk("dark_fd", frame_done, 1'b1);
    go(35);
    chk("dark_f2_an", anodes, 4'hE);
    chk("dark_f2_cat", cathodes, 8'hFF);
    chk("dark_pend", update_pending, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
